// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the bit serializer.
//   state_t : FSM encodings (IDLE, SHIFT, GAP)
//   GAP_W   : width of the inter-word gap counter (supports 0..255 gap cycles)
package bit_serializer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   localparam int GAP_W = 8;

endpackage

// File: rtl/ser_hold_reg.sv
// One-entry WIDTH-bit hold buffer with valid flag.
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset; empties the buffer
//   wr_en   in   store wr_data (only issued while empty)
//   wr_data in   word to store
//   rd_en   in   release the stored word (only issued while full)
//   rd_data out  stored word
//   full    out  buffer holds a word
module ser_hold_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full
);

   logic [WIDTH-1:0] data_r;
   logic             full_r;

   // Buffer contents and occupancy flag
   always_ff @(posedge clk) begin
      if (rst) begin
         data_r <= {WIDTH{1'b0}};
         full_r <= 1'b0;
      end else if (wr_en) begin
         data_r <= wr_data;
         full_r <= 1'b1;
      end else if (rd_en) begin
         full_r <= 1'b0;
      end
   end

   assign rd_data = data_r;
   assign full    = full_r;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder: accepts WIDTH-bit words over valid/ready and
// shifts them out one bit per clock, optionally separated by idle gaps.
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   in_data holds a word to send
//   in_ready   out  hold buffer empty and not in reset
//   in_data    in   parallel word, sampled on the accepting edge only
//   ser_out    out  registered serial bit (0 whenever ser_valid is 0)
//   ser_valid  out  ser_out carries a payload bit
//   word_start out  pulse on the first bit of each word
//   busy       out  shifter or hold buffer occupied
module bit_serializer
   import bit_serializer_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int MSB_FIRST  = 1,
   parameter int GAP_CYCLES = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             word_start,
   output logic             busy
);

   localparam int               CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : GAP_W'(0);

   state_t           state_r, state_nxt_s;
   logic             hold_full_s, hold_wr_s, in_ready_s;
   logic [WIDTH-1:0] hold_data_s;
   logic [WIDTH-1:0] shreg_r;
   logic [CNT_W-1:0] cnt_r;
   logic [GAP_W-1:0] gap_cnt_r;
   logic             ser_out_r, ser_valid_r, word_start_r;
   logic             load_s, shift_s, gap_step_s;
   logic             first_bit_s, next_bit_s;
   logic [WIDTH-1:0] hold_rest_s, shreg_rest_s;

   // No pass-through: a full buffer blocks the source even on its draining cycle.
   assign in_ready_s = ~hold_full_s & ~rst;
   assign hold_wr_s  = in_valid & in_ready_s;

   ser_hold_reg #(.WIDTH(WIDTH)) u_hold (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (hold_wr_s),
      .wr_data (in_data),
      .rd_en   (load_s),
      .rd_data (hold_data_s),
      .full    (hold_full_s)
   );

   // The shifter keeps only the bits not yet sent, aligned so the next one
   // is always at the outgoing end.
   assign first_bit_s  = (MSB_FIRST != 0) ? hold_data_s[WIDTH-1] : hold_data_s[0];
   assign next_bit_s   = (MSB_FIRST != 0) ? shreg_r[WIDTH-1]     : shreg_r[0];
   assign hold_rest_s  = (MSB_FIRST != 0) ? {hold_data_s[WIDTH-2:0], 1'b0} : {1'b0, hold_data_s[WIDTH-1:1]};
   assign shreg_rest_s = (MSB_FIRST != 0) ? {shreg_r[WIDTH-2:0], 1'b0}     : {1'b0, shreg_r[WIDTH-1:1]};

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state and datapath control; cnt_r indexes the bit currently on ser_out
   always_comb begin
      state_nxt_s = state_r;
      load_s      = 1'b0;
      shift_s     = 1'b0;
      gap_step_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (hold_full_s) begin
               load_s      = 1'b1;
               state_nxt_s = ST_SHIFT;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (cnt_r != CNT_LAST) begin
               shift_s = 1'b1;
            end else if (GAP_CYCLES > 0) begin
               state_nxt_s = ST_GAP;
            end else if (hold_full_s) begin
               load_s      = 1'b1;
               state_nxt_s = ST_SHIFT;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_GAP: begin
            // The last gap cycle decides like IDLE so the next word follows
            // after exactly GAP_CYCLES idle cycles.
            if (gap_cnt_r != GAP_LAST) begin
               gap_step_s  = 1'b1;
               state_nxt_s = ST_GAP;
            end else if (hold_full_s) begin
               load_s      = 1'b1;
               state_nxt_s = ST_SHIFT;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Shifter, bit counter and registered serial outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg_r      <= {WIDTH{1'b0}};
         cnt_r        <= {CNT_W{1'b0}};
         ser_out_r    <= 1'b0;
         ser_valid_r  <= 1'b0;
         word_start_r <= 1'b0;
      end else if (load_s) begin
         shreg_r      <= hold_rest_s;
         cnt_r        <= {CNT_W{1'b0}};
         ser_out_r    <= first_bit_s;
         ser_valid_r  <= 1'b1;
         word_start_r <= 1'b1;
      end else if (shift_s) begin
         shreg_r      <= shreg_rest_s;
         cnt_r        <= cnt_r + CNT_W'(1);
         ser_out_r    <= next_bit_s;
         ser_valid_r  <= 1'b1;
         word_start_r <= 1'b0;
      end else begin
         ser_out_r    <= 1'b0;
         ser_valid_r  <= 1'b0;
         word_start_r <= 1'b0;
      end
   end

   // Gap counter, cleared whenever the FSM is not counting idle cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         gap_cnt_r <= GAP_W'(0);
      end else if (gap_step_s) begin
         gap_cnt_r <= gap_cnt_r + GAP_W'(1);
      end else begin
         gap_cnt_r <= GAP_W'(0);
      end
   end

   assign in_ready   = in_ready_s;
   assign ser_out    = ser_out_r;
   assign ser_valid  = ser_valid_r;
   assign word_start = word_start_r;
   assign busy       = (state_r != ST_IDLE) | hold_full_s;

endmodule
